// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC field editors: bus sequencer states,
// register addresses and encoding helpers.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_STROBE,
        ST_A_HOLD,
        ST_D_SETUP,
        ST_D_STROBE,
        ST_D_HOLD,
        ST_DONE
    } seq_state_t;

    localparam logic [7:0] RTC_ADDR_SEC   = 8'h20;
    localparam logic [7:0] RTC_ADDR_MIN   = 8'h21;
    localparam logic [7:0] RTC_ADDR_HOUR  = 8'h22;
    localparam logic [7:0] RTC_ADDR_DATE  = 8'h23;
    localparam logic [7:0] RTC_ADDR_MONTH = 8'h24;
    localparam logic [7:0] RTC_ADDR_YEAR  = 8'h25;
    localparam logic [7:0] RTC_ADDR_DOW   = 8'h26;

    function automatic int unsigned phase_cnt_w(input int unsigned t);
        return (t <= 1) ? 1 : $clog2(t);
    endfunction

    // Packed BCD of 0..99: {tens, ones}.
    function automatic logic [7:0] bin2bcd(input logic [7:0] v);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = v / 8'd10;
        ones = v % 8'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

endpackage

// File: rtl/rtc_write_seq.sv
// Write-only RTC bus sequencer: address phase then data phase, each split
// into setup/strobe/hold of T_PHASE cycles, followed by a one-cycle DONE.
module rtc_write_seq
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_PHASE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    output logic [7:0] bus_data,
    output logic       bus_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad,
    output logic       busy,
    output logic       done
);

    localparam int unsigned    CW   = phase_cnt_w(T_PHASE);
    localparam logic [CW-1:0]  LAST = CW'(T_PHASE - 1);

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic [7:0]    data_q;

    assign rd_n = 1'b1;

    // Pin values are set on the edge that enters each state, so every
    // output is a flop and changes coincide with the state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            data_q   <= '0;
            bus_data <= '0;
            bus_oe   <= 1'b0;
            cs_n     <= 1'b1;
            wr_n     <= 1'b1;
            ad       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state    <= ST_A_SETUP;
                        cnt      <= '0;
                        data_q   <= data;
                        bus_data <= addr;
                        bus_oe   <= 1'b1;
                        cs_n     <= 1'b0;
                        wr_n     <= 1'b1;
                        ad       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt <= '0;
                        case (state)
                            ST_A_SETUP: begin
                                state <= ST_A_STROBE;
                                wr_n  <= 1'b0;
                            end
                            ST_A_STROBE: begin
                                state <= ST_A_HOLD;
                                wr_n  <= 1'b1;
                            end
                            ST_A_HOLD: begin
                                state    <= ST_D_SETUP;
                                ad       <= 1'b1;
                                bus_data <= data_q;
                            end
                            ST_D_SETUP: begin
                                state <= ST_D_STROBE;
                                wr_n  <= 1'b0;
                            end
                            ST_D_STROBE: begin
                                state <= ST_D_HOLD;
                                wr_n  <= 1'b1;
                            end
                            ST_D_HOLD: begin
                                state    <= ST_DONE;
                                cs_n     <= 1'b1;
                                ad       <= 1'b0;
                                bus_oe   <= 1'b0;
                                bus_data <= '0;
                                done     <= 1'b1;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/rtc_field_editor.sv
// One RTC calendar/time field: wrapping up/down counter with direct load,
// and a single-deep pending write that is pushed to the RTC bus sequencer.
module rtc_field_editor
    import rtc_bus_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MIN_VAL  = 1,
    parameter int unsigned MAX_VAL  = 7,
    parameter logic [7:0]  REG_ADDR = RTC_ADDR_DOW,
    parameter bit          BCD      = 1'b1,
    parameter int unsigned T_PHASE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic [7:0]       bus_data,
    output logic             bus_oe,
    output logic             cs_n,
    output logic             rd_n,
    output logic             wr_n,
    output logic             ad,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] SPAN_W = WIDTH'(MAX_VAL - MIN_VAL);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] load_off;
    logic             change;
    logic             pending;
    logic [7:0]       bin_byte;
    logic [7:0]       data_byte;

    // Offset compare: values below MIN wrap to large numbers, so one
    // unsigned test covers both ends of the legal range.
    assign load_off = load_val - MIN_W;

    always_comb begin
        nxt    = value;
        change = 1'b0;
        if (en) begin
            if (load) begin
                if (load_off <= SPAN_W) begin
                    nxt    = load_val;
                    change = 1'b1;
                end
            end else if (up && !down) begin
                nxt    = (value == MAX_W) ? MIN_W : value + WIDTH'(1);
                change = 1'b1;
            end else if (down && !up) begin
                nxt    = (value == MIN_W) ? MAX_W : value - WIDTH'(1);
                change = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value   <= MIN_W;
            pending <= 1'b0;
        end else begin
            value <= nxt;
            if (change) begin
                pending <= 1'b1;
            end else if (pending && !busy) begin
                pending <= 1'b0;
            end
        end
    end

    assign bin_byte  = 8'(value);
    assign data_byte = BCD ? bin2bcd(bin_byte) : bin_byte;

    rtc_write_seq #(
        .T_PHASE (T_PHASE)
    ) u_seq (
        .clk      (clk),
        .rst      (reset),
        .req      (pending),
        .addr     (REG_ADDR),
        .data     (data_byte),
        .bus_data (bus_data),
        .bus_oe   (bus_oe),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .wr_n     (wr_n),
        .ad       (ad),
        .busy     (busy),
        .done     (done)
    );

endmodule

// File: tb/tb_rtc_field_editor.sv
// Bench for rtc_field_editor: a default day-of-week instance (index 0) and a
// BCD minutes instance (index 1), checked against an arithmetic field model.
module tb_rtc_field_editor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en       [2];
    logic       up       [2];
    logic       down     [2];
    logic       load     [2];
    logic [7:0] load_val [2];
    logic [7:0] value    [2];
    logic [7:0] bus_data [2];
    logic       bus_oe   [2];
    logic       cs_n     [2];
    logic       rd_n     [2];
    logic       wr_n     [2];
    logic       ad       [2];
    logic       busy     [2];
    logic       done     [2];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    int          mval [2];
    logic [15:0] txq_a[$];
    logic [15:0] txq_b[$];
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    always #5 clk = ~clk;

    rtc_field_editor dut_a (
        .clk(clk), .reset(rst), .en(en[0]), .up(up[0]), .down(down[0]),
        .load(load[0]), .load_val(load_val[0]), .value(value[0]),
        .bus_data(bus_data[0]), .bus_oe(bus_oe[0]), .cs_n(cs_n[0]), .rd_n(rd_n[0]),
        .wr_n(wr_n[0]), .ad(ad[0]), .busy(busy[0]), .done(done[0])
    );

    rtc_field_editor #(
        .WIDTH(8), .MIN_VAL(0), .MAX_VAL(59), .REG_ADDR(8'h21), .BCD(1'b1), .T_PHASE(2)
    ) dut_b (
        .clk(clk), .reset(rst), .en(en[1]), .up(up[1]), .down(down[1]),
        .load(load[1]), .load_val(load_val[1]), .value(value[1]),
        .bus_data(bus_data[1]), .bus_oe(bus_oe[1]), .cs_n(cs_n[1]), .rd_n(rd_n[1]),
        .wr_n(wr_n[1]), .ad(ad[1]), .busy(busy[1]), .done(done[1])
    );

    function automatic int vmin(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int vmax(input int i);
        return (i == 0) ? 7 : 59;
    endfunction

    function automatic logic [7:0] reg_addr(input int i);
        return (i == 0) ? 8'h26 : 8'h21;
    endfunction

    function automatic logic [7:0] enc(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // ops: 0 up, 1 down, 2 load, 3 up+down, 4 up with en=0, 5 load+up
    function automatic int model_next(input int i, input int op, input int lv, output bit acc);
        int lo, hi, span, v;
        lo = vmin(i); hi = vmax(i); span = hi - lo + 1; v = mval[i];
        acc = 1'b1;
        if (op == 0) return lo + (v - lo + 1) % span;
        if (op == 1) return lo + (v - lo + span - 1) % span;
        if ((op == 2 || op == 5) && lv >= lo && lv <= hi) return lv;
        acc = 1'b0;
        return v;
    endfunction

    // Bus monitor: strobe protocol plus one record per completed transaction.
    logic [7:0] st_byte [2];
    logic       st_ad   [2];
    logic       wr_prev [2];
    logic [7:0] addr_seen [2];
    logic [7:0] data_seen [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                wr_prev[i] = 1'b1;
            end else begin
                if (wr_n[i] === 1'b0) begin
                    vectors++;
                    if (cs_n[i] !== 1'b0) begin
                        miscompares++;
                        $display("FAIL strobe_cs dut%0d: cs_n=%b required 0 while wr_n=0", i, cs_n[i]);
                    end
                    if (wr_prev[i] === 1'b1) begin
                        st_byte[i] = bus_data[i];
                        st_ad[i]   = ad[i];
                        if (ad[i]) data_seen[i] = bus_data[i];
                        else       addr_seen[i] = bus_data[i];
                    end else begin
                        vectors++;
                        if (bus_data[i] !== st_byte[i] || ad[i] !== st_ad[i]) begin
                            miscompares++;
                            $display("FAIL strobe_stable dut%0d: got %h/%b required %h/%b",
                                     i, bus_data[i], ad[i], st_byte[i], st_ad[i]);
                        end
                    end
                end
                if (done[i] === 1'b1) begin
                    if (i == 0) txq_a.push_back({addr_seen[i], data_seen[i]});
                    else        txq_b.push_back({addr_seen[i], data_seen[i]});
                end
                wr_prev[i] = wr_n[i];
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_queues();
        txq_a.delete(); txq_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic pulse(input int i, input int op, input int lv);
        bit acc;
        int nv;
        @(posedge clk); #1;
        case (op)
            0: up[i] = 1'b1;
            1: down[i] = 1'b1;
            2: begin load[i] = 1'b1; load_val[i] = 8'(lv); end
            3: begin up[i] = 1'b1; down[i] = 1'b1; end
            4: begin en[i] = 1'b0; up[i] = 1'b1; end
            default: begin load[i] = 1'b1; up[i] = 1'b1; load_val[i] = 8'(lv); end
        endcase
        nv = model_next(i, op, lv, acc);
        if (acc) begin
            mval[i] = nv;
            if (i == 0) exp_a.push_back({reg_addr(0), enc(nv)});
            else        exp_b.push_back({reg_addr(1), enc(nv)});
        end
        @(posedge clk); #1;
        up[i] = 1'b0; down[i] = 1'b0; load[i] = 1'b0; en[i] = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({value[i], cs_n[i], rd_n[i], wr_n[i], ad[i], bus_data[i], bus_oe[i], busy[i], done[i]}
                !== {8'(vmin(i)), 4'b1110, 8'h00, 3'b000}) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: value=%0d cs_n=%b rd_n=%b wr_n=%b ad=%b bus=%h oe=%b busy=%b done=%b",
                         i, value[i], cs_n[i], rd_n[i], wr_n[i], ad[i], bus_data[i], bus_oe[i], busy[i], done[i]);
            end
        end
        rst = 1'b0;
        idle(5);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({value[i], cs_n[i], wr_n[i], busy[i], bus_oe[i]} !== {8'(vmin(i)), 4'b1100}) begin
                miscompares++;
                $display("FAIL post_reset_idle dut%0d: value=%0d cs_n=%b wr_n=%b busy=%b oe=%b",
                         i, value[i], cs_n[i], wr_n[i], busy[i], bus_oe[i]);
            end
        end
    endtask

    task automatic test_up_sequence();
        clear_queues();
        for (int n = 0; n < 8; n++) begin
            pulse(0, (n == 7) ? 1 : 0, 0);
            idle(30);
            vectors++;
            if (value[0] !== 8'(mval[0])) begin
                miscompares++;
                $display("FAIL up_seq_value step%0d: got %0d required %0d", n, value[0], mval[0]);
            end
        end
        vectors++;
        if (txq_a.size() != exp_a.size()) begin
            miscompares++;
            $display("FAIL up_seq_count: got %0d writes required %0d", txq_a.size(), exp_a.size());
        end
        for (int k = 0; k < exp_a.size() && k < txq_a.size(); k++) begin
            vectors++;
            if (txq_a[k] !== exp_a[k]) begin
                miscompares++;
                $display("FAIL up_seq_write%0d: got %h required %h", k, txq_a[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_bus_timing();
        int ph;
        logic [13:0] got, req;
        bit acc;
        @(posedge clk); #1;
        up[0] = 1'b1;
        mval[0] = model_next(0, 0, 0, acc);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 1) up[0] = 1'b0;
            @(negedge clk);
            ph = (k >= 2 && k <= 25) ? (k - 2) / 4 : -1;
            req = {ph < 0, !(ph == 1 || ph == 4), ph >= 3, k == 26, k >= 2 && k <= 26, ph >= 0,
                   (ph < 0) ? 8'h00 : (ph < 3) ? 8'h26 : enc(mval[0])};
            got = {cs_n[0], wr_n[0], ad[0], done[0], busy[0], bus_oe[0], bus_data[0]};
            vectors++;
            if (got !== req) begin
                miscompares++;
                $display("FAIL bus_timing cycle%0d: {cs_n,wr_n,ad,done,busy,oe,data}=%h required %h", k, got, req);
            end
        end
    endtask

    task automatic test_bcd_load();
        int lv [7] = '{45, 60, 59, 0, 0, 1, 0};
        int op [7] = '{2, 2, 2, 0, 1, 1, 2};
        clear_queues();
        for (int n = 0; n < 7; n++) begin
            pulse(1, op[n], lv[n]);
            idle(30);
            vectors++;
            if (value[1] !== 8'(mval[1])) begin
                miscompares++;
                $display("FAIL bcd_value step%0d: got %0d required %0d", n, value[1], mval[1]);
            end
        end
        vectors++;
        if (txq_b.size() != exp_b.size()) begin
            miscompares++;
            $display("FAIL bcd_count: got %0d writes required %0d", txq_b.size(), exp_b.size());
        end
        for (int k = 0; k < exp_b.size() && k < txq_b.size(); k++) begin
            vectors++;
            if (txq_b[k] !== exp_b[k]) begin
                miscompares++;
                $display("FAIL bcd_write%0d: got %h required %h", k, txq_b[k], exp_b[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] first;
        clear_queues();
        pulse(0, 0, 0);
        first = exp_a[0];
        idle(3);
        for (int n = 0; n < 3; n++) begin
            pulse(0, 0, 0);
            idle(2);
        end
        exp_a = '{first, exp_a[$]};
        idle(60);
        pulse(0, 3, 0);
        idle(30);
        pulse(0, 4, 0);
        idle(30);
        pulse(0, 5, 3);
        idle(30);
        vectors++;
        if (value[0] !== 8'(mval[0])) begin
            miscompares++;
            $display("FAIL b2b_value: got %0d required %0d", value[0], mval[0]);
        end
        vectors++;
        if (txq_a.size() != exp_a.size()) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d writes required %0d", txq_a.size(), exp_a.size());
        end
        for (int k = 0; k < exp_a.size() && k < txq_a.size(); k++) begin
            vectors++;
            if (txq_a[k] !== exp_a[k]) begin
                miscompares++;
                $display("FAIL b2b_write%0d: got %h required %h", k, txq_a[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        clear_queues();
        @(posedge clk); #1;
        up[0] = 1'b1;
        mval[0] = model_next(0, 0, 0, acc);
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
            if (k == 1) up[0] = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if ({wr_n[0], ad[0], cs_n[0]} !== 3'b010) begin
            miscompares++;
            $display("FAIL mid_d_strobe: {wr_n,ad,cs_n}=%b required 010", {wr_n[0], ad[0], cs_n[0]});
        end
        rst = 1'b1;
        #1;
        mval[0] = vmin(0);
        mval[1] = vmin(1);
        vectors++;
        if ({cs_n[0], wr_n[0], busy[0], done[0], bus_oe[0], value[0]} !== {5'b11000, 8'(mval[0])}) begin
            miscompares++;
            $display("FAIL mid_reset_abort: cs_n=%b wr_n=%b busy=%b done=%b oe=%b value=%0d",
                     cs_n[0], wr_n[0], busy[0], done[0], bus_oe[0], value[0]);
        end
        idle(2);
        rst = 1'b0;
        idle(40);
        vectors++;
        if (txq_a.size() != 0 || txq_b.size() != 0 || value[0] !== 8'(mval[0])) begin
            miscompares++;
            $display("FAIL mid_reset_nowrite: writes=%0d/%0d value=%0d required 0/0 %0d",
                     txq_a.size(), txq_b.size(), value[0], mval[0]);
        end
    endtask

    task automatic test_random();
        int i, op, lv;
        clear_queues();
        for (int n = 0; n < 40; n++) begin
            i  = int'($urandom_range(0, 1));
            op = int'($urandom_range(0, 5));
            lv = int'($urandom_range(0, vmax(i) + 3));
            pulse(i, op, lv);
            idle(30);
            vectors++;
            if (value[i] !== 8'(mval[i])) begin
                miscompares++;
                $display("FAIL rand_value iter%0d dut%0d op%0d: got %0d required %0d", n, i, op, value[i], mval[i]);
            end
        end
        vectors++;
        if (txq_a.size() != exp_a.size() || txq_b.size() != exp_b.size()) begin
            miscompares++;
            $display("FAIL rand_count: got %0d/%0d writes required %0d/%0d",
                     txq_a.size(), txq_b.size(), exp_a.size(), exp_b.size());
        end
        for (int k = 0; k < exp_a.size() && k < txq_a.size(); k++) begin
            vectors++;
            if (txq_a[k] !== exp_a[k]) begin
                miscompares++;
                $display("FAIL rand_write_a%0d: got %h required %h", k, txq_a[k], exp_a[k]);
            end
        end
        for (int k = 0; k < exp_b.size() && k < txq_b.size(); k++) begin
            vectors++;
            if (txq_b[k] !== exp_b[k]) begin
                miscompares++;
                $display("FAIL rand_write_b%0d: got %h required %h", k, txq_b[k], exp_b[k]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, miscompares=%0d", miscompares);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b1; up[i] = 1'b0; down[i] = 1'b0; load[i] = 1'b0; load_val[i] = 8'h00;
            mval[i] = vmin(i);
        end
        idle(3);
        test_reset();
        test_up_sequence();
        test_bus_timing();
        idle(10);
        test_bcd_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
